// File: rtl/controle_divisor8_pkg.sv
// controle_divisor8_pkg
//   Shared definitions for the sequential restoring divider: FSM state
//   encoding, default widths and the quotient reported for a zero divisor.
package controle_divisor8_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = 4;
    localparam int MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIM  = 2'd2
    } state_t;

    // Quotient reported for a zero divisor: all ones, sliced to WIDTH by users.
    localparam logic [MAX_WIDTH-1:0] QUO_DIV_ZERO = '1;

endpackage

// File: rtl/controle_divisor8_if.sv
// controle_divisor8_if
//   Requester-side handshake and operand/result bus of the divider.
//   master : requester (drives start and operands, receives status/results)
//   slave  : divider   (receives start and operands, drives status/results)
//   start            request, sampled only while the divider is idle
//   dividendo/divisor operands, captured when start is accepted
//   busy/done        run in progress / one-cycle completion pulse
//   div_zero         completed run had a zero divisor
//   quociente/resto  results, held until the next accepted start
interface controle_divisor8_if
    import controle_divisor8_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);

    logic             start;
    logic [WIDTH-1:0] dividendo;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] quociente;
    logic [WIDTH-1:0] resto;

    modport master (
        output start, dividendo, divisor,
        input  busy, done, div_zero, quociente, resto
    );

    modport slave (
        input  start, dividendo, divisor,
        output busy, done, div_zero, quociente, resto
    );

endinterface

// File: rtl/controle_divisor8_sub_borrow_n.sv
// sub_borrow_n
//   Combinational WIDTH-bit subtractor. s = a - b on WIDTH+1 bits; s[WIDTH]
//   is the borrow (1 when a < b).
//   a, b : WIDTH-bit unsigned operands
//   s    : WIDTH+1-bit result, borrow in the MSB
module sub_borrow_n
    import controle_divisor8_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   s
);

    // Zero-extending both operands makes the extra MSB the borrow out.
    assign s = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/controle_divisor8.sv
// controle_divisor8
//   Sequential restoring divider. One shared subtractor is reused for WIDTH
//   iterations to produce an unsigned quotient and remainder.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, discards any run in progress
//   bus   : start/busy/done handshake, operands and results (slave side)
module controle_divisor8
    import controle_divisor8_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF   // needs 2**CNT_W > WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    controle_divisor8_if.slave  bus
);

    state_t           state, state_next;
    logic [WIDTH-1:0] r_q, q_q, d_q;
    logic [WIDTH-1:0] quo_q, rem_q;
    logic             dz_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH:0]   p;       // partial remainder shifted left with next dividend bit
    logic [WIDTH:0]   s;       // p[WIDTH-1:0] - D, borrow in MSB
    logic             ge;      // p >= D: quotient bit for this iteration
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;
    logic             accept;
    logic             last;

    assign accept = (state == IDLE) && bus.start;
    assign last   = (cnt_q == CNT_W'(WIDTH - 1));

    assign p = {r_q, q_q[WIDTH-1]};

    sub_borrow_n #(.WIDTH(WIDTH)) u_sub (
        .a (p[WIDTH-1:0]),
        .b (d_q),
        .s (s)
    );

    // If p overflowed into bit WIDTH it is certainly >= D, even though the
    // truncated subtraction reports a borrow.
    assign ge     = p[WIDTH] | ~s[WIDTH];
    assign r_next = ge ? s[WIDTH-1:0] : p[WIDTH-1:0];
    assign q_next = {q_q[WIDTH-2:0], ge};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: next state is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.start) state_next = (bus.divisor == '0) ? FIM : CALC;
            CALC: if (last)      state_next = FIM;
            FIM:                 state_next = IDLE;
            default:             state_next = IDLE;
        endcase
    end

    // NOTE: every datapath register is a flop (no memory arrays), so all of
    // them are cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q   <= '0;
            q_q   <= '0;
            d_q   <= '0;
            cnt_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dz_q  <= 1'b0;
        end else if (accept) begin
            d_q   <= bus.divisor;
            q_q   <= bus.dividendo;
            r_q   <= '0;
            cnt_q <= '0;
            if (bus.divisor == '0) begin
                quo_q <= QUO_DIV_ZERO[WIDTH-1:0];
                rem_q <= bus.dividendo;
                dz_q  <= 1'b1;
            end else begin
                quo_q <= '0;
                rem_q <= '0;
                dz_q  <= 1'b0;
            end
        end else if (state == CALC) begin
            r_q   <= r_next;
            q_q   <= q_next;
            cnt_q <= cnt_q + 1'b1;
            // Results are published on the edge entering FIM so they are
            // already valid in the cycle done is high.
            if (last) begin
                quo_q <= q_next;
                rem_q <= r_next;
            end
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == FIM);
    assign bus.div_zero  = dz_q;
    assign bus.quociente = quo_q;
    assign bus.resto     = rem_q;

endmodule

// File: tb/tb_controle_divisor8.sv
// tb_controle_divisor8
//   Self-checking bench for controle_divisor8: table-driven vectors, random
//   vectors against an arithmetic model, and hand-written sequences for
//   start-while-busy, start held through FIM, and mid-run reset.
module tb_controle_divisor8;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        int         lat;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        exp_t       e;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    controle_divisor8_if #(.WIDTH(8)) bus ();

    controle_divisor8 #(.WIDTH(8), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        if (b == 8'd0) begin
            e.q = 8'hFF; e.r = a; e.dz = 1'b1; e.lat = 1;
        end else begin
            e.q = a / b; e.r = a % b; e.dz = 1'b0; e.lat = 9;
        end
        return e;
    endfunction

    // Compare the DUT results with the oldest scoreboard entry.
    task automatic pop_compare(input string tag, input int n);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, " scoreboard_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        check({tag, " quociente"}, 32'(bus.quociente), 32'(e.q));
        check({tag, " resto"},     32'(bus.resto),     32'(e.r));
        check({tag, " div_zero"},  32'(bus.div_zero),  32'(e.dz));
        check({tag, " latency"},   32'(n),             32'(e.lat));
    endtask

    // One run: start pulsed for one cycle; operands scrambled after acceptance.
    // If poke > 0, a second start with 50/5 is pulsed in observed cycle poke.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input exp_t e, input int poke);
        int n;
        int busy_n;
        logic [7:0] hq, hr;
        sb_q.push_back(e);
        bus.dividendo = a;
        bus.divisor   = b;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
        bus.dividendo = 8'($urandom);
        bus.divisor   = 8'($urandom);
        n      = 1;
        busy_n = 0;
        if (e.lat > 1) begin
            check({tag, " accept_clears_quo"}, 32'(bus.quociente), 32'd0);
            check({tag, " accept_clears_dz"},  32'(bus.div_zero),  32'd0);
        end
        while (!bus.done && n < 40) begin
            if (bus.busy) busy_n++;
            tick();
            n++;
            if (n == poke) begin
                bus.start     = 1'b1;
                bus.dividendo = 8'd50;
                bus.divisor   = 8'd5;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        if (bus.busy) busy_n++;
        check({tag, " done_seen"}, 32'(bus.done), 32'd1);
        check({tag, " busy_cycles"}, 32'(busy_n), 32'(e.lat));
        hq = bus.quociente;
        hr = bus.resto;
        pop_compare(tag, n);
        tick();
        check({tag, " done_one_cycle"}, 32'(bus.done), 32'd0);
        check({tag, " idle_after"},     32'(bus.busy), 32'd0);
        check({tag, " quo_held"},       32'(bus.quociente), 32'(hq));
        check({tag, " rem_held"},       32'(bus.resto),     32'(hr));
    endtask

    initial begin
        vec_t tbl[11];
        int   n;
        int   done_n;
        logic [7:0] ra, rb;

        tbl[0]  = '{8'd200, 8'd7,   '{8'd28,  8'd4,   1'b0, 9}};
        tbl[1]  = '{8'd255, 8'd1,   '{8'd255, 8'd0,   1'b0, 9}};
        tbl[2]  = '{8'd5,   8'd9,   '{8'd0,   8'd5,   1'b0, 9}};
        tbl[3]  = '{8'd255, 8'd200, '{8'd1,   8'd55,  1'b0, 9}};
        tbl[4]  = '{8'd255, 8'd255, '{8'd1,   8'd0,   1'b0, 9}};
        tbl[5]  = '{8'd77,  8'd0,   '{8'd255, 8'd77,  1'b1, 1}};
        tbl[6]  = '{8'd10,  8'd3,   '{8'd3,   8'd1,   1'b0, 9}};
        tbl[7]  = '{8'd0,   8'd5,   '{8'd0,   8'd0,   1'b0, 9}};
        tbl[8]  = '{8'd1,   8'd255, '{8'd0,   8'd1,   1'b0, 9}};
        tbl[9]  = '{8'd254, 8'd255, '{8'd0,   8'd254, 1'b0, 9}};
        tbl[10] = '{8'd128, 8'd2,   '{8'd64,  8'd0,   1'b0, 9}};

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.dividendo = 8'd0;
        bus.divisor   = 8'd0;
        repeat (3) tick();
        check("reset busy",      32'(bus.busy),      32'd0);
        check("reset done",      32'(bus.done),      32'd0);
        check("reset div_zero",  32'(bus.div_zero),  32'd0);
        check("reset quociente", 32'(bus.quociente), 32'd0);
        check("reset resto",     32'(bus.resto),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 11; i++)
            run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].e, 0);

        for (int i = 0; i < 16; i++) begin
            ra = 8'($urandom);
            rb = (i % 5 == 4) ? 8'd0 : 8'($urandom_range(1, 255));
            run_op($sformatf("rnd%0d", i), ra, rb, model(ra, rb), 0);
        end

        // Start pulsed while busy with new operands: ignored.
        run_op("busy_start", 8'd100, 8'd9, '{8'd11, 8'd1, 1'b0, 9}, 4);

        // Start held high through FIM: ignored there, accepted in next IDLE.
        sb_q.push_back('{8'd3, 8'd1, 1'b0, 9});
        sb_q.push_back('{8'd3, 8'd1, 1'b0, 9});
        bus.dividendo = 8'd10;
        bus.divisor   = 8'd3;
        bus.start     = 1'b1;
        tick();
        n = 1;
        while (!bus.done && n < 40) begin tick(); n++; end
        check("held done_seen", 32'(bus.done), 32'd1);
        pop_compare("held run1", n);
        tick();
        check("held fim_ignored", 32'(bus.busy), 32'd0);
        tick();
        check("held restart", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        n = 1;
        while (!bus.done && n < 40) begin tick(); n++; end
        check("held run2 done_seen", 32'(bus.done), 32'd1);
        pop_compare("held run2", n);
        tick();

        // Reset asserted mid-run: everything clears at once, no done pulse.
        bus.dividendo = 8'd200;
        bus.divisor   = 8'd7;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        check("rst busy_before", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst busy",      32'(bus.busy),      32'd0);
        check("rst done",      32'(bus.done),      32'd0);
        check("rst div_zero",  32'(bus.div_zero),  32'd0);
        check("rst quociente", 32'(bus.quociente), 32'd0);
        check("rst resto",     32'(bus.resto),     32'd0);
        done_n = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.done) done_n++;
        end
        rst_n = 1'b1;
        repeat (12) begin
            tick();
            if (bus.done || bus.busy) done_n++;
        end
        check("rst no_done_after", 32'(done_n), 32'd0);
        run_op("after_rst", 8'd200, 8'd7, '{8'd28, 8'd4, 1'b0, 9}, 0);

        check("scoreboard drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
